pixel_write_arbiter: RTL and testbench
======================================

Name: pixel_write_arbiter

Overview:
- Shares the single pixel-RAM write port (pr_data / pr_wraddress / pr_wren) between NUM_REQ pixel producers, e.g. parallel Mandelbrot compute cores.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Contains a clear-screen sequencer that sweeps the whole frame with CLEAR_VALUE and has priority over all requesters.
- Tracks frame completion by counting accepted in-range pixel writes.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 20: pixel-RAM write address width.
- DATA_W, 8: pixel data width.
- FRAME_PIXELS, 307200: pixels per frame (640x480); valid addresses are 0..FRAME_PIXELS-1.
- CLEAR_VALUE, 8'h00: data written by the clear sweep.

Ports:
- sys_clk  in  1  system clock; all logic is on this clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept; a handshake occurs when valid & ready.
- req_data  in  NUM_REQ*DATA_W  packed pixel data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_addr  in  NUM_REQ*ADDR_W  packed pixel addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- clear_start  in  1  single-cycle pulse that starts a frame clear.
- clear_busy  out  1  high while the clear sweep runs.
- frame_done  out  1  sticky; set when pixel_count reaches FRAME_PIXELS.
- addr_err  out  1  sticky; set when an out-of-range address is accepted.
- pixel_count  out  ADDR_W  accepted in-range writes since the last clear or reset.
- pr_data  out  DATA_W  to pixel-RAM data input.
- pr_wraddress  out  ADDR_W  to pixel-RAM write address.
- pr_wren  out  1  to pixel-RAM write enable.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0; state=RUN; round-robin pointer=0; clear address=0.
- States:
  - RUN: arbitration active.
  - CLEAR: sweep active.
- RUN arbitration:
  - Requests are scanned starting at (last_grant+1) mod NUM_REQ.
  - The first requester with req_valid is granted.
  - At most one req_ready bit is high per cycle. req_ready is combinational from req_valid and the pointer, and is high only for the granted index.
  - No requester may be granted twice in a row while another requester is waiting.
  - The pointer updates only on a handshake.
- Write latency:
  - A handshake in cycle N drives pr_wren=1 in cycle N+1, with the registered data and address.
  - Otherwise pr_wren=0, and pr_data / pr_wraddress hold their previous values.
- Range check:
  - If accepted req_addr >= FRAME_PIXELS, the write is dropped (no pr_wren), addr_err is set, and pixel_count is unchanged.
- Counting:
  - Each in-range handshake increments pixel_count. Overwrites of the same address still count.
  - frame_done is set in the cycle after pixel_count becomes FRAME_PIXELS.
  - pixel_count saturates at FRAME_PIXELS; further writes still reach the RAM.
- clear_start in RUN:
  - req_ready is forced to 0 in that same cycle, so clear has priority with no handshake.
  - Next cycle: state=CLEAR, clear_busy=1, clear address=0.
  - pixel_count, frame_done and addr_err are cleared in the same cycle as the state change.
- CLEAR:
  - req_ready=0.
  - Each cycle writes clear address k with CLEAR_VALUE, so pr_wren=1 one cycle later with pr_wraddress=k; then k increments.
  - After k = FRAME_PIXELS-1 is issued: state returns to RUN and clear_busy=0 in the following cycle.
  - The sweep lasts exactly FRAME_PIXELS cycles. The last pr_wren coincides with the first RUN cycle.
  - Requests may be granted in that first RUN cycle; their pr_wren appears one cycle later, so there is no port conflict.
- clear_start during CLEAR: the sweep restarts at address 0 on the next cycle and clear_busy stays high.
- Simultaneous reset and clear_start: reset wins; state=RUN, no clear.
- Reset mid-CLEAR: abort the sweep immediately; RAM contents are left partially cleared.
- Requester behaviour while stalled: a requester whose req_valid is low for a cycle loses no priority. Data and address must be held stable by the requester until it is granted; the block does not check this.

Decomposition:
- Package pixel_arb_pkg holds:
  - state enum {RUN, CLEAR};
  - default constants FRAME_PIXELS_640x480=307200 and CLEAR_VALUE;
  - helper function clog2.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - inputs: req vector, advance strobe;
  - output: one-hot grant;
  - owns the rotating pointer.
- The top level owns the FSM, sweep counter, pixel counter and output registers.

Test Plan:
- Reset with FRAME_PIXELS=16 -> all outputs 0. One requester (req 1) with addr=5, data=8'hAB: req_ready[1]=1 the same cycle; next cycle pr_wren=1, pr_wraddress=5, pr_data=AB; pixel_count=1.
- All 4 requesters hold valid continuously -> grants follow 0,1,2,3,0,... one per cycle. pr_wren stays high every cycle. After 16 writes frame_done=1 and pixel_count=16 (saturated).
- Requester 2 sends addr=16 with FRAME_PIXELS=16 -> handshake completes, pr_wren stays 0, addr_err=1, pixel_count unchanged.
- clear_start pulsed in the same cycle requesters 0 and 3 are valid -> req_ready=0 that cycle. Then 16 consecutive pr_wren with addresses 0..15 and data 00. clear_busy is high for 16 cycles. frame_done, addr_err and pixel_count are all 0. Request 0 is granted in the first RUN cycle.
- clear_start pulsed again at sweep address 7 -> pr_wraddress restarts at 0 and the total sweep runs 8+16 cycles.
- reset asserted at sweep address 9 -> next cycle state=RUN, clear_busy=0, pr_wren=0, and no further clear writes.

Source files
------------

// File: rtl/pixel_arb_pkg.sv
// Shared types, default constants and helpers for the pixel write arbiter.
package pixel_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int unsigned FRAME_PIXELS_640x480 = 307200;
  localparam logic [7:0]  CLEAR_VALUE_DEFAULT  = 8'h00;

  // Ceiling log2; returns at least 1 so a pointer is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanned from the rotating start pointer.
module rr_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] grant_idx;
  logic             found;
  int unsigned      scan_idx;

  // Scan from the pointer; on an accepted grant the pointer moves past the winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && req[PTR_W'(scan_idx)]) begin
        found                   = 1'b1;
        grant[PTR_W'(scan_idx)] = 1'b1;
        grant_idx               = PTR_W'(scan_idx);
      end
    end
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Shares the pixel-RAM write port between NUM_REQ producers, with a
// priority clear-screen sweep and frame completion tracking.
module pixel_write_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int unsigned       NUM_REQ      = 4,
  parameter int unsigned       ADDR_W       = 20,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       FRAME_PIXELS = FRAME_PIXELS_640x480,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = DATA_W'(CLEAR_VALUE_DEFAULT)
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      frame_done,
  output logic                      addr_err,
  output logic [ADDR_W-1:0]         pixel_count,
  output logic [DATA_W-1:0]         pr_data,
  output logic [ADDR_W-1:0]         pr_wraddress,
  output logic                      pr_wren
);

  localparam logic [ADDR_W:0]   FRAME_LIMIT = (ADDR_W + 1)'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_PIXELS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0]   pixel_count_q, pixel_count_d;
  logic [ADDR_W-1:0]   pr_wraddress_q, pr_wraddress_d;
  logic [DATA_W-1:0]   pr_data_q, pr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                addr_err_q, addr_err_d;
  logic                pr_wren_q, pr_wren_d;

  logic [NUM_REQ-1:0]  grant;
  logic                handshake;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                addr_in_range;
  logic                count_full;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (sys_clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (handshake),
    .grant   (grant)
  );

  // Accept only in RUN, and never in a cycle that requests a clear or reset.
  assign req_ready = (state_q == RUN && !clear_start && !reset) ? grant : '0;
  assign handshake = |req_ready;

  // Select the accepted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign addr_in_range = {1'b0, sel_addr} < FRAME_LIMIT;
  assign count_full    = {1'b0, pixel_count_q} == FRAME_LIMIT;

  // Next-state logic for the FSM, sweep counter, pixel counter and RAM port.
  always_comb begin
    state_d        = state_q;
    clr_addr_d     = clr_addr_q;
    pixel_count_d  = pixel_count_q;
    pr_wraddress_d = pr_wraddress_q;
    pr_data_d      = pr_data_q;
    pr_wren_d      = 1'b0;
    addr_err_d     = addr_err_q;
    frame_done_d   = frame_done_q | count_full;
    unique case (state_q)
      RUN: begin
        if (clear_start) begin
          state_d       = CLEAR;
          clr_addr_d    = '0;
          pixel_count_d = '0;
          frame_done_d  = 1'b0;
          addr_err_d    = 1'b0;
        end else if (handshake) begin
          if (addr_in_range) begin
            pr_wren_d      = 1'b1;
            pr_wraddress_d = sel_addr;
            pr_data_d      = sel_data;
            if (!count_full) pixel_count_d = pixel_count_q + 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        // The address in flight is still written when a restart arrives.
        pr_wren_d      = 1'b1;
        pr_wraddress_d = clr_addr_q;
        pr_data_d      = CLEAR_VALUE;
        if (clear_start) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == LAST_ADDR) begin
          state_d    = RUN;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q        <= RUN;
      clr_addr_q     <= '0;
      pixel_count_q  <= '0;
      pr_wraddress_q <= '0;
      pr_data_q      <= '0;
      pr_wren_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_addr_q     <= clr_addr_d;
      pixel_count_q  <= pixel_count_d;
      pr_wraddress_q <= pr_wraddress_d;
      pr_data_q      <= pr_data_d;
      pr_wren_q      <= pr_wren_d;
      frame_done_q   <= frame_done_d;
      addr_err_q     <= addr_err_d;
    end
  end

  assign clear_busy   = (state_q == CLEAR);
  assign frame_done   = frame_done_q;
  assign addr_err     = addr_err_q;
  assign pixel_count  = pixel_count_q;
  assign pr_data      = pr_data_q;
  assign pr_wraddress = pr_wraddress_q;
  assign pr_wren      = pr_wren_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: directed vector table, hand-written clear
// sequences, then randomized traffic against a behavioural model.
module tb_pixel_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int FP = 16;
  localparam logic [DW-1:0] CV = 8'h00;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*DW-1:0] rdata;
  logic [N*AW-1:0] raddr;
  logic            busy, done, err, wren;
  logic [AW-1:0]   cnt, waddr;
  logic [DW-1:0]   wdata;

  always #5 clk = ~clk;

  pixel_write_arbiter #(
    .NUM_REQ      (N),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .FRAME_PIXELS (FP),
    .CLEAR_VALUE  (CV)
  ) dut (
    .sys_clk      (clk),
    .reset        (rst),
    .req_valid    (valid),
    .req_ready    (ready),
    .req_data     (rdata),
    .req_addr     (raddr),
    .clear_start  (clr),
    .clear_busy   (busy),
    .frame_done   (done),
    .addr_err     (err),
    .pixel_count  (cnt),
    .pr_data      (wdata),
    .pr_wraddress (waddr),
    .pr_wren      (wren)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit c, input logic [N-1:0] v,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    rst   = r;
    clr   = c;
    valid = v;
    raddr = {N{a}};
    rdata = {N{d}};
  endtask

  typedef struct {
    bit           rst;
    bit           clr;
    logic [N-1:0] valid;
    logic [7:0]   addr;
    logic [7:0]   data;
    logic [N-1:0] e_ready;
    bit           e_wren;
    logic [7:0]   e_waddr;
    logic [7:0]   e_wdata;
    logic [7:0]   e_count;
    bit           e_done;
    bit           e_err;
    bit           e_busy;
  } vec_t;

  function automatic vec_t mk(bit r, bit c, logic [N-1:0] v, logic [7:0] a, logic [7:0] d,
                              logic [N-1:0] er, bit ew, logic [7:0] ea, logic [7:0] ed,
                              logic [7:0] ec, bit edn, bit eer, bit eb);
    vec_t t;
    t.rst = r; t.clr = c; t.valid = v; t.addr = a; t.data = d;
    t.e_ready = er; t.e_wren = ew; t.e_waddr = ea; t.e_wdata = ed;
    t.e_count = ec; t.e_done = edn; t.e_err = eer; t.e_busy = eb;
    return t;
  endfunction

  vec_t tbl[$];

  // Behavioural reference state for the random phase.
  int m_ptr, m_sweep, m_count, m_waddr, m_wdata;
  bit m_busy, m_done, m_err, m_wren;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra[N];
    logic [DW-1:0] rd[N];
    logic [N-1:0]  er;
    int            g, idx;
    bit            r, c, nd;
    string         tag;

    // Vector table: reset state, single grant, out-of-range drop, rotation and saturation.
    tbl.push_back(mk(0,0,4'b0000, 8'd0, 8'h00, 4'b0000,0,8'd0,8'h00,8'd0,0,0,0));
    tbl.push_back(mk(0,0,4'b0010, 8'd5, 8'hAB, 4'b0010,0,8'd0,8'h00,8'd0,0,0,0));
    tbl.push_back(mk(0,0,4'b0000, 8'd0, 8'h00, 4'b0000,1,8'd5,8'hAB,8'd1,0,0,0));
    tbl.push_back(mk(0,0,4'b0100, 8'd16,8'h55, 4'b0100,0,8'd5,8'hAB,8'd1,0,0,0));
    tbl.push_back(mk(0,0,4'b0000, 8'd0, 8'h00, 4'b0000,0,8'd5,8'hAB,8'd1,0,1,0));
    tbl.push_back(mk(1,0,4'b0000, 8'd0, 8'h00, 4'b0000,0,8'd5,8'hAB,8'd1,0,1,0));
    for (int k = 0; k < 18; k++) begin
      tbl.push_back(mk(0,0,4'b1111, 8'(k % 16), 8'(8'h40 + k), 4'(1 << (k % 4)),
                       k > 0, k > 0 ? 8'((k - 1) % 16) : 8'd0, k > 0 ? 8'(8'h3F + k) : 8'h00,
                       8'(k > 16 ? 16 : k), k >= 17, 0, 0));
    end
    tbl.push_back(mk(0,0,4'b0000, 8'd0, 8'h00, 4'b0000,1,8'd1,8'h51,8'd16,1,0,0));

    drive(1, 0, '0, '0, '0);
    next_cycle();
    next_cycle();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].valid, tbl[i].addr, tbl[i].data);
      #3;
      tag = $sformatf("row%0d", i);
      chk({tag, " ready"}, 32'(ready), 32'(tbl[i].e_ready));
      chk({tag, " wren"},  32'(wren),  32'(tbl[i].e_wren));
      chk({tag, " waddr"}, 32'(waddr), 32'(tbl[i].e_waddr));
      chk({tag, " wdata"}, 32'(wdata), 32'(tbl[i].e_wdata));
      chk({tag, " count"}, 32'(cnt),   32'(tbl[i].e_count));
      chk({tag, " done"},  32'(done),  32'(tbl[i].e_done));
      chk({tag, " err"},   32'(err),   32'(tbl[i].e_err));
      chk({tag, " busy"},  32'(busy),  32'(tbl[i].e_busy));
      next_cycle();
    end

    // Clear with requesters 0 and 3 waiting; requester 3 first leaves the pointer at 0.
    drive(0, 0, 4'b1000, 8'd20, 8'h99);
    #3; chk("pre ready", 32'(ready), 32'(4'b1000));
    next_cycle();
    drive(0, 1, 4'b1001, 8'd3, 8'h77);
    #3;
    chk("clr ready", 32'(ready), 32'(4'b0000));
    chk("clr err",   32'(err), 32'(1));
    next_cycle();
    clr = 0;
    for (int cy = 1; cy <= 16; cy++) begin
      #3;
      tag = $sformatf("sweep%0d", cy);
      chk({tag, " busy"},  32'(busy),  32'(1));
      chk({tag, " ready"}, 32'(ready), 32'(0));
      chk({tag, " count"}, 32'(cnt),   32'(0));
      chk({tag, " done"},  32'(done),  32'(0));
      chk({tag, " err"},   32'(err),   32'(0));
      chk({tag, " wren"},  32'(wren),  32'(cy > 1));
      if (cy > 1) begin
        chk({tag, " waddr"}, 32'(waddr), 32'(cy - 2));
        chk({tag, " wdata"}, 32'(wdata), 32'(CV));
      end
      next_cycle();
    end
    #3;
    chk("run1 busy",  32'(busy),  32'(0));
    chk("run1 wren",  32'(wren),  32'(1));
    chk("run1 waddr", 32'(waddr), 32'(15));
    chk("run1 ready", 32'(ready), 32'(4'b0001));
    next_cycle();
    valid = '0;
    #3;
    chk("run2 wren",  32'(wren),  32'(1));
    chk("run2 waddr", 32'(waddr), 32'(3));
    chk("run2 wdata", 32'(wdata), 32'(8'h77));
    chk("run2 count", 32'(cnt),   32'(1));
    next_cycle();

    // Restart mid-sweep at address 7: addresses 0..7 then 0..15.
    drive(0, 1, '0, '0, '0);
    next_cycle();
    for (int cy = 1; cy <= 25; cy++) begin
      clr = (cy == 8);
      #3;
      tag = $sformatf("restart%0d", cy);
      chk({tag, " busy"}, 32'(busy), 32'(cy <= 24));
      chk({tag, " wren"}, 32'(wren), 32'(cy > 1));
      if (cy > 1) chk({tag, " waddr"}, 32'(waddr), 32'(cy - 2 < 8 ? cy - 2 : cy - 10));
      next_cycle();
    end
    clr = 0;
    #3;
    chk("restart end wren", 32'(wren), 32'(0));
    chk("restart end busy", 32'(busy), 32'(0));
    next_cycle();

    // Reset while sweep address 9 is being issued.
    drive(0, 1, '0, '0, '0);
    next_cycle();
    clr = 0;
    for (int cy = 1; cy <= 10; cy++) begin
      rst = (cy == 10);
      #3;
      chk($sformatf("abort%0d busy", cy), 32'(busy), 32'(1));
      if (cy == 10) chk("abort waddr", 32'(waddr), 32'(8));
      next_cycle();
    end
    rst = 0;
    for (int cy = 0; cy < 4; cy++) begin
      #3;
      chk($sformatf("post%0d busy", cy), 32'(busy), 32'(0));
      chk($sformatf("post%0d wren", cy), 32'(wren), 32'(0));
      chk($sformatf("post%0d waddr", cy), 32'(waddr), 32'(0));
      next_cycle();
    end

    // Randomized traffic against the reference model.
    drive(1, 0, '0, '0, '0);
    next_cycle();
    m_ptr = 0; m_sweep = 0; m_count = 0; m_waddr = 0; m_wdata = 0;
    m_busy = 0; m_done = 0; m_err = 0; m_wren = 0;
    for (int cy = 0; cy < 600; cy++) begin
      r = ($urandom_range(0, 149) == 0);
      c = ($urandom_range(0, 39) == 0);
      rst = r;
      clr = c;
      for (int i = 0; i < N; i++) begin
        valid[i] = ($urandom_range(0, 3) != 0);
        ra[i] = AW'($urandom_range(0, 19));
        rd[i] = DW'($urandom);
        raddr[i*AW +: AW] = ra[i];
        rdata[i*DW +: DW] = rd[i];
      end
      #3;
      g = -1;
      if (!r && !c && !m_busy) begin
        for (int j = 0; j < N; j++) begin
          idx = (m_ptr + j) % N;
          if (g < 0 && valid[idx]) g = idx;
        end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      tag = $sformatf("rnd%0d", cy);
      chk({tag, " ready"}, 32'(ready), 32'(er));
      chk({tag, " wren"},  32'(wren),  32'(m_wren));
      chk({tag, " waddr"}, 32'(waddr), 32'(m_waddr));
      chk({tag, " wdata"}, 32'(wdata), 32'(m_wdata));
      chk({tag, " count"}, 32'(cnt),   32'(m_count));
      chk({tag, " done"},  32'(done),  32'(m_done));
      chk({tag, " err"},   32'(err),   32'(m_err));
      chk({tag, " busy"},  32'(busy),  32'(m_busy));
      if (r) begin
        m_ptr = 0; m_sweep = 0; m_count = 0; m_waddr = 0; m_wdata = 0;
        m_busy = 0; m_done = 0; m_err = 0; m_wren = 0;
      end else begin
        nd = m_done || (m_count == FP);
        if (m_busy) begin
          m_wren = 1; m_waddr = m_sweep; m_wdata = int'(CV); m_done = nd;
          if (c) m_sweep = 0;
          else if (m_sweep == FP - 1) begin m_busy = 0; m_sweep = 0; end
          else m_sweep++;
        end else if (c) begin
          m_busy = 1; m_sweep = 0; m_count = 0; m_done = 0; m_err = 0; m_wren = 0;
        end else begin
          m_wren = 0; m_done = nd;
          if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (int'(ra[g]) < FP) begin
              m_wren = 1; m_waddr = int'(ra[g]); m_wdata = int'(rd[g]);
              if (m_count < FP) m_count++;
            end else begin
              m_err = 1;
            end
          end
        end
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
